// File: rtl/data_mem_responder_pkg.sv
// Shared defaults, state encoding and counter width for the data-memory responder.
package data_mem_responder_pkg;

  localparam int unsigned MEM_WORD_LEN  = 32;
  localparam int unsigned MEM_BASE_ADDR = 1024;
  localparam int unsigned MEM_DEPTH     = 64;
  localparam int unsigned MEM_LATENCY   = 3;
  localparam int unsigned MEMR_CNT_LEN  = 4;

  typedef enum logic [1:0] {
    MemrIdle = 2'd0,
    MemrBusy = 2'd1,
    MemrDone = 2'd2
  } memr_state_e;

endpackage

// File: rtl/data_mem_array.sv
// Word array with synchronous write, synchronous registered read and reset clear.
module data_mem_array #(
  parameter int unsigned WORD_LEN = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned IDX_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    index,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] rdata
);

  logic [WORD_LEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem_q[index] <= wdata;
      end
      if (re) begin
        rdata <= mem_q[index];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: fixed-latency load/store with pipeline freeze and ready pulse.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned WORD_LEN  = MEM_WORD_LEN,
  parameter int unsigned DEPTH     = MEM_DEPTH,
  parameter int unsigned BASE_ADDR = MEM_BASE_ADDR,
  parameter int unsigned LATENCY   = MEM_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [WORD_LEN-1:0] ALU_res,
  input  logic [WORD_LEN-1:0] ST_value,
  output logic [WORD_LEN-1:0] dataMem_out,
  output logic                ready,
  output logic                mem_freeze,
  output logic                addr_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  memr_state_e             state_q;
  logic [MEMR_CNT_LEN-1:0] cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [WORD_LEN-1:0]     wdata_q;
  logic                    wr_q, ill_q, both_q;
  logic                    ready_q, err_q, zero_q;

  logic                req, launch, finish, in_ill;
  logic [WORD_LEN-1:0] offset, word;
  logic [IdxW-1:0]     in_idx, c_idx;
  logic [WORD_LEN-1:0] c_wdata, arr_rdata;
  logic                c_wr, c_ill, c_both, arr_we, arr_re;

  always_comb begin
    req    = MEM_R_EN | MEM_W_EN;
    offset = ALU_res - WORD_LEN'(BASE_ADDR);
    word   = offset >> 2;
    in_ill = (ALU_res[1:0] != 2'b00) || (ALU_res < WORD_LEN'(BASE_ADDR)) ||
             (word >= WORD_LEN'(DEPTH));
    in_idx = word[IdxW-1:0];
    launch = (state_q == MemrIdle) && req;
    // Completion edge is the one before the ready cycle, so with LATENCY=1 the
    // accepting edge itself completes and BUSY is skipped.
    finish = (launch && (LATENCY == 1)) ||
             ((state_q == MemrBusy) && (cnt_q == MEMR_CNT_LEN'(1)));
    c_idx   = launch ? in_idx   : idx_q;
    c_wdata = launch ? ST_value : wdata_q;
    c_wr    = launch ? MEM_W_EN : wr_q;
    c_ill   = launch ? in_ill   : ill_q;
    c_both  = launch ? (MEM_R_EN & MEM_W_EN) : both_q;
    arr_we  = finish && c_wr && !c_ill;
    arr_re  = finish && !c_wr && !c_ill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MemrIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      both_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      ready_q <= finish;
      err_q   <= finish && (c_ill || c_both);
      if (finish && !c_wr) begin
        zero_q <= c_ill;
      end
      unique case (state_q)
        MemrIdle: begin
          if (req) begin
            idx_q   <= in_idx;
            wdata_q <= ST_value;
            wr_q    <= MEM_W_EN;
            ill_q   <= in_ill;
            both_q  <= MEM_R_EN & MEM_W_EN;
            cnt_q   <= MEMR_CNT_LEN'(LATENCY - 1);
            state_q <= finish ? MemrDone : MemrBusy;
          end
        end
        MemrBusy: begin
          if (finish) begin
            state_q <= MemrDone;
          end else begin
            cnt_q <= cnt_q - MEMR_CNT_LEN'(1);
          end
        end
        MemrDone: state_q <= MemrIdle;
        default:  state_q <= MemrIdle;
      endcase
    end
  end

  data_mem_array #(
    .WORD_LEN(WORD_LEN),
    .DEPTH   (DEPTH),
    .IDX_W   (IdxW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .index(c_idx),
    .wdata(c_wdata),
    .rdata(arr_rdata)
  );

  // An errored read reports zero without disturbing the array's read register.
  assign dataMem_out = zero_q ? '0 : arr_rdata;
  assign ready       = ready_q;
  assign addr_err    = err_q;
  assign mem_freeze  = req & ~ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: directed and random accesses against a word-array reference model.
module tb_data_mem_responder;

  typedef struct {
    logic        err;
    logic [31:0] dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [31:0] alu = '0, st = '0;
  bit          sel = 1'b0;

  logic        r3, w3, r1, w1;
  logic [31:0] a3, s3, a1, s1;
  logic [31:0] dout3, dout1, dout;
  logic        rdy3, frz3, err3, rdy1, frz1, err1, rdy, frz, err;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic [31:0] mdl_mem [64];
  logic [31:0] mdl_dout;

  always #5 clk = ~clk;

  assign r3 = sel ? 1'b0 : r_en;
  assign w3 = sel ? 1'b0 : w_en;
  assign a3 = sel ? '0 : alu;
  assign s3 = sel ? '0 : st;
  assign r1 = sel ? r_en : 1'b0;
  assign w1 = sel ? w_en : 1'b0;
  assign a1 = sel ? alu : '0;
  assign s1 = sel ? st : '0;

  assign dout = sel ? dout1 : dout3;
  assign rdy  = sel ? rdy1 : rdy3;
  assign frz  = sel ? frz1 : frz3;
  assign err  = sel ? err1 : err3;

  data_mem_responder #(.LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .MEM_R_EN(r3), .MEM_W_EN(w3), .ALU_res(a3), .ST_value(s3),
    .dataMem_out(dout3), .ready(rdy3), .mem_freeze(frz3), .addr_err(err3)
  );

  data_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .ALU_res(a1), .ST_value(s1),
    .dataMem_out(dout1), .ready(rdy1), .mem_freeze(frz1), .addr_err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    mdl_dout = '0;
    q.delete();
  endtask

  // Entered and left just after a rising edge.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    bit          ill, got;
    int unsigned stalls, idx;
    exp_t        e;
    r_en = r; w_en = w; alu = a; st = d;
    ill = (a[1:0] != 2'b00) || (a < 32'd1024) || (((a - 32'd1024) / 4) >= 64);
    idx = ill ? 0 : (a - 32'd1024) / 4;
    if (w) begin
      e.err = ill || r;
      if (!ill) mdl_mem[idx] = d;
    end else begin
      e.err = ill;
      mdl_dout = ill ? 32'd0 : mdl_mem[idx];
    end
    e.dout = mdl_dout;
    q.push_back(e);
    stalls = 0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy) begin
        got = 1'b1;
        break;
      end
      if (frz) stalls++;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    chk("stall_cycles", stalls, sel ? 32'd1 : 32'd3);
    chk("freeze_at_ready", {31'd0, frz}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    r_en = 1'b0; w_en = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_freeze", {31'd0, frz}, 32'd0);
      chk("idle_ready", {31'd0, rdy}, 32'd0);
      chk("idle_dout", dout, mdl_dout);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic random_run(input int n);
    logic [31:0] a;
    int unsigned k;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7)       a = 32'd1024 + 4 * $urandom_range(0, 63);
      else if (k == 7) a = 32'd1024 + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
      else if (k == 8) a = 32'd1024 + 4 * $urandom_range(64, 100);
      else             a = 32'd1024 - 4 * $urandom_range(1, 50);
      k = $urandom_range(0, 9);
      access(k < 5 || k == 9, k >= 5, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  // Scoreboard monitor: every ready pulse consumes one expected response.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("addr_err", {31'd0, err}, {31'd0, mon_e.err});
        chk("dataMem_out", dout, mon_e.dout);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1'b0;
    do_reset();
    idle(10);

    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    idle(1);
    access(1'b1, 1'b0, 32'd1024, 32'd0);
    idle(3);

    access(1'b0, 1'b1, 32'd1028, 32'd5);
    access(1'b0, 1'b1, 32'd1032, 32'd7);
    access(1'b1, 1'b0, 32'd1028, 32'd0);
    access(1'b1, 1'b0, 32'd1032, 32'd0);
    idle(1);

    access(1'b1, 1'b0, 32'd1026, 32'd0);
    access(1'b1, 1'b0, 32'd1024 + 4 * 64, 32'd0);
    access(1'b0, 1'b1, 32'd1020, 32'd9);
    access(1'b1, 1'b0, 32'd1024, 32'd0);
    idle(1);

    // Reset in the second BUSY cycle of a store: the write must be lost.
    r_en = 1'b0; w_en = 1'b1; alu = 32'd1040; st = 32'h55;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_reset_ready", {31'd0, rdy}, 32'd0);
    chk("post_reset_dout", dout, 32'd0);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'd1040, 32'd0);
    idle(1);

    random_run(60);
    idle(2);

    sel = 1'b1;
    do_reset();
    idle(2);
    access(1'b1, 1'b1, 32'd1044, 32'h11);
    access(1'b1, 1'b0, 32'd1044, 32'd0);
    idle(1);
    random_run(40);
    idle(2);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
